// File: rtl/load_unit_if.sv
// Handshaked word-read port between the M-stage load unit and data memory.
// The load unit is the master: it raises mem_req with mem_addr until mem_gnt, then waits for mem_rvalid.
interface load_unit_if;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/load_unit.sv
// M-stage load unit: issues one word read per lw/lh/lhu/lb/lbu, stalls until data returns,
// extracts and extends the addressed byte/halfword, and reports address and bus errors.
module load_unit #(
    parameter logic [31:0] DM_LIMIT = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ALUout_M,
    input  logic [2:0]         loadselM,
    input  logic [31:0]        NPC,
    input  logic               Exception,
    load_unit_if.master        mem,
    output logic               StallM,
    output logic [31:0]        LoadData_W,
    output logic               LoadValid_W,
    output logic               AdEL,
    output logic               BusErr,
    output logic [31:0]        ErrPC
);

    localparam logic [2:0] LD_W  = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_HU = 3'd3;
    localparam logic [2:0] LD_B  = 3'd4;
    localparam logic [2:0] LD_BU = 3'd5;
    localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] npc_q, npc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        adel_q, adel_d;
    logic        buserr_q, buserr_d;
    logic [31:0] errpc_q, errpc_d;

    logic        is_load;
    logic        misaligned;
    logic        stall;
    logic [3:0]  cnt_inc;
    logic        timed_out;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] ext_v;

    always_comb begin
        is_load    = (loadselM != 3'd0) && (loadselM <= LD_BU);
        misaligned = 1'b0;
        if (loadselM == LD_W) begin
            misaligned = (ALUout_M[1:0] != 2'b00);
        end else if ((loadselM == LD_H) || (loadselM == LD_HU)) begin
            misaligned = ALUout_M[0];
        end
        cnt_inc   = cnt_q + 4'd1;
        timed_out = (cnt_inc == TIMEOUT_C);
    end

    // Byte/halfword lane selection uses the offset latched at issue, not the live address.
    always_comb begin
        half_v = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (off_q)
            2'd0:    byte_v = mem.mem_rdata[7:0];
            2'd1:    byte_v = mem.mem_rdata[15:8];
            2'd2:    byte_v = mem.mem_rdata[23:16];
            default: byte_v = mem.mem_rdata[31:24];
        endcase
        case (type_q)
            LD_H:    ext_v = {{16{half_v[15]}}, half_v};
            LD_HU:   ext_v = {16'h0000, half_v};
            LD_B:    ext_v = {{24{byte_v[7]}}, byte_v};
            LD_BU:   ext_v = {24'h000000, byte_v};
            default: ext_v = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        off_d        = off_q;
        type_d       = type_q;
        npc_d        = npc_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        adel_d       = 1'b0;
        buserr_d     = 1'b0;
        errpc_d      = errpc_q;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_load && !Exception) begin
                    if (misaligned || (ALUout_M >= DM_LIMIT)) begin
                        adel_d  = 1'b1;
                        errpc_d = NPC;
                    end else begin
                        mem_addr_d = {ALUout_M[31:2], 2'b00};
                        off_d      = ALUout_M[1:0];
                        type_d     = loadselM;
                        npc_d      = NPC;
                        mem_req_d  = 1'b1;
                        stall      = 1'b1;
                        state_d    = REQ;
                    end
                end
            end

            // A flush that coincides with the grant still has data in flight, so it must drain.
            REQ: begin
                stall = 1'b1;
                if (mem.mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = 4'd0;
                    state_d   = Exception ? DRAIN : WAIT;
                end else if (Exception) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            WAIT: begin
                stall = !mem.mem_rvalid;
                cnt_d = cnt_inc;
                if (mem.mem_rvalid) begin
                    state_d = IDLE;
                    if (!Exception) begin
                        load_data_d  = ext_v;
                        load_valid_d = 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = IDLE;
                    if (!Exception) begin
                        buserr_d = 1'b1;
                        errpc_d  = npc_q;
                    end
                end else if (Exception) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                stall = !mem.mem_rvalid;
                cnt_d = cnt_inc;
                if (mem.mem_rvalid || timed_out) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'h0;
            off_q        <= 2'd0;
            type_q       <= 3'd0;
            npc_q        <= 32'h0;
            cnt_q        <= 4'd0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            adel_q       <= 1'b0;
            buserr_q     <= 1'b0;
            errpc_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            off_q        <= off_d;
            type_q       <= type_d;
            npc_q        <= npc_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            adel_q       <= adel_d;
            buserr_q     <= buserr_d;
            errpc_q      <= errpc_d;
        end
    end

    // The stall is combinational, so hold it low while reset is asserted.
    assign StallM       = reset & stall;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign LoadData_W   = load_data_q;
    assign LoadValid_W  = load_valid_q;
    assign AdEL         = adel_q;
    assign BusErr       = buserr_q;
    assign ErrPC        = errpc_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios followed by randomized loads,
// compared against a word-memory reference model of load extraction and error rules.
module tb_load_unit;

    localparam logic [31:0] DM_LIMIT = 32'h0000_3000;
    localparam int          MEM_WORDS = 3072;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_TIMEOUT = 1;
    localparam int MODE_EXCWAIT = 2;
    localparam int MODE_EXCREQ  = 3;
    localparam int MODE_RESET   = 4;

    logic        clk;
    logic        reset;
    logic [31:0] ALUout_M;
    logic [2:0]  loadselM;
    logic [31:0] NPC;
    logic        Exception;
    logic        StallM;
    logic [31:0] LoadData_W;
    logic        LoadValid_W;
    logic        AdEL;
    logic        BusErr;
    logic [31:0] ErrPC;

    load_unit_if bus ();

    load_unit dut (
        .clk         (clk),
        .reset       (reset),
        .ALUout_M    (ALUout_M),
        .loadselM    (loadselM),
        .NPC         (NPC),
        .Exception   (Exception),
        .mem         (bus),
        .StallM      (StallM),
        .LoadData_W  (LoadData_W),
        .LoadValid_W (LoadValid_W),
        .AdEL        (AdEL),
        .BusErr      (BusErr),
        .ErrPC       (ErrPC)
    );

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] memWords [MEM_WORDS];
    logic [31:0] lastData;
    logic [31:0] lastErrPc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: value a load of the given type returns from an aligned memory word.
    function automatic logic [31:0] refLoad(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] v;
        int unsigned shiftAmt;
        shiftAmt = 8 * (addr % 4);
        case (sel)
            3'd1: v = word;
            3'd2, 3'd3: begin
                v = (word >> ((addr % 4 >= 2) ? 16 : 0)) & 32'h0000_FFFF;
                if (sel == 3'd2 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            3'd4, 3'd5: begin
                v = (word >> shiftAmt) & 32'h0000_00FF;
                if (sel == 3'd4 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic bit refIsLoad(input logic [2:0] sel);
        return (sel >= 3'd1) && (sel <= 3'd5);
    endfunction

    function automatic bit refAddrError(input logic [2:0] sel, input logic [31:0] addr);
        if (addr >= DM_LIMIT) return 1'b1;
        if (sel == 3'd1 && (addr % 4) != 0) return 1'b1;
        if ((sel == 3'd2 || sel == 3'd3) && (addr % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(LoadValid_W), 32'd0);
        checkOutput({tag, "_adel"}, 32'(AdEL), 32'd0);
        checkOutput({tag, "_buserr"}, 32'(BusErr), 32'd0);
        checkOutput({tag, "_data"}, LoadData_W, lastData);
        checkOutput({tag, "_errpc"}, ErrPC, lastErrPc);
    endtask

    // Runs one M-stage instruction from an IDLE unit, acting as both pipeline and memory.
    task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] npc,
                                 input int gntLat, input int rvLat, input int mode, input int excAt);
        logic [31:0] word;
        logic [31:0] expData;
        word = (addr < DM_LIMIT) ? memWords[addr >> 2] : 32'h0;
        expData = refLoad(sel, addr, word);
        loadselM = sel; ALUout_M = addr; NPC = npc; Exception = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        if (!refIsLoad(sel) || refAddrError(sel, addr)) begin
            checkOutput("noissue_stall", 32'(StallM), 32'd0);
            tick();
            loadselM = 3'd0;
            #1;
            checkOutput("noissue_req", 32'(bus.mem_req), 32'd0);
            checkOutput("adel_pulse", 32'(AdEL), 32'(refIsLoad(sel)));
            if (refIsLoad(sel)) lastErrPc = npc;
            checkOutput("adel_errpc", ErrPC, lastErrPc);
            checkOutput("noissue_valid", 32'(LoadValid_W), 32'd0);
            tick();
            checkOutput("adel_clear", 32'(AdEL), 32'd0);
            return;
        end
        checkOutput("issue_stall", 32'(StallM), 32'd1);
        tick();
        checkOutput("req_high", 32'(bus.mem_req), 32'd1);
        checkOutput("req_addr", bus.mem_addr, {addr[31:2], 2'b00});
        for (int i = 0; i < gntLat; i++) begin
            #1;
            checkOutput("req_stall", 32'(StallM), 32'd1);
            checkOutput("req_hold", 32'(bus.mem_req), 32'd1);
            tick();
        end
        if (mode == MODE_EXCREQ) begin
            Exception = 1'b1; loadselM = 3'd0;
            #1;
            checkOutput("excreq_stall", 32'(StallM), 32'd1);
            tick();
            Exception = 1'b0;
            #1;
            checkOutput("excreq_req", 32'(bus.mem_req), 32'd0);
            checkOutput("excreq_stall_off", 32'(StallM), 32'd0);
            checkIdleOutputs("excreq");
            return;
        end
        bus.mem_gnt = 1'b1;
        #1;
        checkOutput("gnt_stall", 32'(StallM), 32'd1);
        tick();
        bus.mem_gnt = 1'b0;
        checkOutput("wait_req", 32'(bus.mem_req), 32'd0);
        if (mode == MODE_TIMEOUT) begin
            for (int i = 0; i < 15; i++) begin
                #1;
                checkOutput("to_stall", 32'(StallM), 32'd1);
                checkOutput("to_early", 32'(BusErr), 32'd0);
                tick();
            end
            loadselM = 3'd0;
            #1;
            lastErrPc = npc;
            checkOutput("to_buserr", 32'(BusErr), 32'd1);
            checkOutput("to_errpc", ErrPC, lastErrPc);
            checkOutput("to_stall_off", 32'(StallM), 32'd0);
            checkOutput("to_valid", 32'(LoadValid_W), 32'd0);
            tick();
            checkOutput("to_clear", 32'(BusErr), 32'd0);
            return;
        end
        if (mode == MODE_EXCWAIT) begin
            for (int i = 0; i < excAt; i++) begin
                #1;
                checkOutput("excw_stall", 32'(StallM), 32'd1);
                tick();
            end
            Exception = 1'b1; loadselM = 3'd0;
            #1;
            checkOutput("excw_flush_stall", 32'(StallM), 32'd1);
            tick();
            Exception = 1'b0;
            for (int i = 0; i < rvLat; i++) begin
                #1;
                checkOutput("drain_stall", 32'(StallM), 32'd1);
                tick();
            end
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
            #1;
            checkOutput("drain_rv_stall", 32'(StallM), 32'd0);
            tick();
            bus.mem_rvalid = 1'b0;
            #1;
            checkOutput("drain_stall_off", 32'(StallM), 32'd0);
            checkIdleOutputs("drain");
            return;
        end
        if (mode == MODE_RESET) begin
            for (int i = 0; i < excAt; i++) begin
                #1;
                checkOutput("rst_wait_stall", 32'(StallM), 32'd1);
                tick();
            end
            reset = 1'b0; loadselM = 3'd0;
            tick();
            lastData = 32'h0; lastErrPc = 32'h0;
            checkOutput("rst_req", 32'(bus.mem_req), 32'd0);
            checkOutput("rst_addr", bus.mem_addr, 32'h0);
            checkOutput("rst_stall", 32'(StallM), 32'd0);
            checkIdleOutputs("rst");
            reset = 1'b1;
            bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
            #1;
            checkOutput("rst_rv_stall", 32'(StallM), 32'd0);
            tick();
            bus.mem_rvalid = 1'b0;
            checkIdleOutputs("rst_late_rv");
            return;
        end
        for (int i = 0; i < rvLat - 1; i++) begin
            #1;
            checkOutput("wait_stall", 32'(StallM), 32'd1);
            checkOutput("wait_novalid", 32'(LoadValid_W), 32'd0);
            tick();
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
        #1;
        checkOutput("rv_stall", 32'(StallM), 32'd0);
        tick();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom; loadselM = 3'd0;
        #1;
        lastData = expData;
        checkOutput("load_valid", 32'(LoadValid_W), 32'd1);
        checkOutput("load_data", LoadData_W, expData);
        checkOutput("load_stall_off", 32'(StallM), 32'd0);
        tick();
        checkIdleOutputs("after_load");
    endtask

    initial begin
        logic [2:0]  rSel;
        logic [31:0] rAddr;
        int          rMode;
        int          pick;

        for (int i = 0; i < MEM_WORDS; i++) memWords[i] = $urandom;
        memWords[4] = 32'h8765_43A1;
        lastData = 32'h0; lastErrPc = 32'h0;

        reset = 1'b0; ALUout_M = 32'h0; loadselM = 3'd0; NPC = 32'h0; Exception = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        tick();
        tick();
        checkOutput("reset_req", 32'(bus.mem_req), 32'd0);
        checkOutput("reset_addr", bus.mem_addr, 32'h0);
        checkOutput("reset_stall", 32'(StallM), 32'd0);
        checkIdleOutputs("reset");
        reset = 1'b1;
        tick();

        $display("[TB] directed loads");
        applyStimulus(3'd4, 32'h10, 32'h100, 0, 2, MODE_NORMAL, 0);
        checkOutput("lb_0x10", lastData, 32'hFFFF_FFA1);
        applyStimulus(3'd5, 32'h13, 32'h104, 0, 2, MODE_NORMAL, 0);
        checkOutput("lbu_0x13", lastData, 32'h0000_0087);
        applyStimulus(3'd2, 32'h12, 32'h108, 1, 1, MODE_NORMAL, 0);
        checkOutput("lh_0x12", lastData, 32'hFFFF_8765);
        applyStimulus(3'd3, 32'h10, 32'h10C, 2, 3, MODE_NORMAL, 0);
        checkOutput("lhu_0x10", lastData, 32'h0000_43A1);
        applyStimulus(3'd1, 32'h10, 32'h110, 0, 1, MODE_NORMAL, 0);
        checkOutput("lw_0x10", lastData, 32'h8765_43A1);

        $display("[TB] directed errors");
        applyStimulus(3'd1, 32'h6, 32'h3004, 0, 1, MODE_NORMAL, 0);
        applyStimulus(3'd4, 32'h3000, 32'h3008, 0, 1, MODE_NORMAL, 0);
        applyStimulus(3'd5, 32'h2FFF, 32'h300C, 0, 1, MODE_NORMAL, 0);
        applyStimulus(3'd1, 32'h40, 32'h4000, 0, 1, MODE_TIMEOUT, 0);
        applyStimulus(3'd1, 32'h44, 32'h4004, 0, 2, MODE_NORMAL, 0);
        applyStimulus(3'd1, 32'h48, 32'h4008, 1, 1, MODE_EXCWAIT, 0);
        applyStimulus(3'd4, 32'h11, 32'h400C, 0, 2, MODE_NORMAL, 0);
        applyStimulus(3'd2, 32'h50, 32'h4010, 1, 1, MODE_EXCREQ, 0);
        applyStimulus(3'd1, 32'h54, 32'h4014, 0, 1, MODE_RESET, 2);
        applyStimulus(3'd3, 32'h56, 32'h4018, 0, 1, MODE_NORMAL, 0);

        $display("[TB] random loads");
        for (int n = 0; n < 120; n++) begin
            rSel = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 9);
            if (pick < 7)      rAddr = 32'($urandom_range(0, 32'h2FFF));
            else if (pick < 9) rAddr = 32'($urandom_range(32'h2FF8, 32'h3007));
            else               rAddr = $urandom;
            pick = $urandom_range(0, 19);
            if (pick < 14)      rMode = MODE_NORMAL;
            else if (pick < 16) rMode = MODE_EXCWAIT;
            else if (pick < 18) rMode = MODE_EXCREQ;
            else if (pick < 19) rMode = MODE_TIMEOUT;
            else                rMode = MODE_RESET;
            applyStimulus(rSel, rAddr, $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
                          rMode, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Read-side counterpart of the data memory store path; handles lw/lh/lhu/lb/lbu in the M stage.
- Issues word reads to a handshaked memory read port and stalls the pipeline while the read is outstanding.
- Selects and extends the addressed byte or halfword, then registers the result toward W.
- Flags misaligned, out-of-range and timed-out loads as address/bus errors.

Parameters:
- DM_LIMIT, 32'h0000_3000, first byte address outside data memory; a load hits when ALUout_M < DM_LIMIT.
- TIMEOUT, 15, maximum WAIT cycles before a bus error; counter width is 4 bits, so TIMEOUT ≤ 15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ALUout_M  in  32  load byte address.
- loadselM  in  3  000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 treated as none.
- NPC  in  32  PC of the load, carried for error reporting.
- Exception  in  1  M-stage flush; kills the load in this stage.
- mem_req  out  1  read request, held until accepted.
- mem_gnt  in  1  request accepted this cycle.
- mem_addr  out  32  word address {ALUout_M[31:2],2'b00}, latched.
- mem_rvalid  in  1  read data valid (1 cycle, at least 1 cycle after gnt).
- mem_rdata  in  32  read word.
- StallM  out  1  freeze F/D/E/M.
- LoadData_W  out  32  extended load result (registered).
- LoadValid_W  out  1  1-cycle pulse with LoadData_W.
- AdEL  out  1  1-cycle pulse: misaligned or out-of-range load.
- BusErr  out  1  1-cycle pulse: read timed out.
- ErrPC  out  32  NPC of the faulting load, valid with AdEL/BusErr.

Behaviour:
- Reset values: state IDLE; mem_req=0, mem_addr=0, LoadData_W=0, LoadValid_W=0, AdEL=0, BusErr=0, ErrPC=0, timeout counter=0.
- Reset mid-operation: return to IDLE immediately; any later rvalid is ignored.
- Alignment rule: lw requires addr[1:0]=00; lh/lhu require addr[0]=0; lb/lbu are always aligned.

State IDLE:
- With load && !Exception:
  - misaligned or addr ≥ DM_LIMIT: AdEL=1 and ErrPC=NPC next cycle, no request, stay IDLE, StallM=0.
  - otherwise: latch word address, addr[1:0], type and NPC; assert mem_req; go to REQ.
- StallM=1 combinationally in the IDLE cycle that starts a request.

State REQ:
- mem_req=1 and StallM=1.
- On mem_gnt: drop mem_req, clear counter, go to WAIT.

State WAIT:
- StallM=1; counter increments each cycle.
- On mem_rvalid: extract and extend, register LoadData_W, pulse LoadValid_W next cycle, go to IDLE.
  - StallM drops in the rvalid cycle, so the pipeline advances on the same edge that registers data.
- Counter reaching TIMEOUT without rvalid: BusErr=1 and ErrPC=latched NPC, go to IDLE.
- rvalid and timeout in the same cycle: rvalid wins.

State DRAIN:
- Entered on Exception during REQ or WAIT.
- From REQ, before gnt: drop mem_req and go straight to IDLE.
- From WAIT: StallM=1; on the next rvalid discard the data (no LoadValid_W), go to IDLE.
- Timeout also applies in DRAIN, but raises no BusErr.

Extraction and extension (offset o = latched addr[1:0]):
- lw: the full word.
- lh/lhu: halfword = o[1] ? rdata[31:16] : rdata[15:0]; lh sign-extends, lhu zero-extends.
- lb/lbu: byte rdata[8*o+7 : 8*o]; lb sign-extends, lbu zero-extends.

Other rules:
- At most one outstanding read; no new request is accepted until back in IDLE.

Test Plan:
- Word memory 0x10 = 0x8765_43A1; lb at 0x10 → 1 cycle REQ (gnt), rvalid 2 cycles later → LoadData_W=0xFFFF_FFA1, LoadValid_W pulse; StallM high from issue cycle through the cycle before rvalid.
- Same word: lbu 0x13 → 0x0000_0087; lh 0x12 → 0xFFFF_8765; lhu 0x10 → 0x0000_43A1; lw 0x10 → 0x8765_43A1.
- lw at 0x0000_0006 with NPC=0x3004 → AdEL pulse, ErrPC=0x3004, mem_req never asserted, StallM=0. lb at 0x3000 → AdEL.
- Grant, then no rvalid for 15 cycles → BusErr pulse, ErrPC latched, back in IDLE. A subsequent lw completes normally.
- Exception asserted in WAIT, rvalid 3 cycles later with 0xDEAD_BEEF → no LoadValid_W, StallM held until rvalid, then 0. Next load returns correct data.
- reset=0 while in WAIT → all outputs 0 next cycle. rvalid after reset release is ignored; no LoadValid_W.
